// File: rtl/hdmi_rd_sched_if.sv
// rtl/hdmi_rd_sched_if.sv - burst read request/response bundle between scheduler and memory reader
interface hdmi_rd_sched_if;
    logic        rd_req;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_done;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_len,
        input  rd_ack,
        input  rd_done
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_len,
        output rd_ack,
        output rd_done
    );
endinterface

// File: rtl/hdmi_rd_sched.sv
// rtl/hdmi_rd_sched.sv - frame buffer burst read scheduler feeding the HDMI line FIFO
module hdmi_rd_sched #(
    parameter logic [27:0] FB_BASE      = 28'h0000000,
    parameter int          LINE_STRIDE  = 8192,
    parameter int          H_ACT        = 1920,
    parameter int          V_ACT        = 1080,
    parameter int          PIX_PER_BEAT = 8,
    parameter int          BEAT_BYTES   = 32,
    parameter int          BURST_BEATS  = 16,
    parameter int          FIFO_DEPTH   = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sched_en,
    input  logic                  vs_in,
    input  logic                  de_in,
    input  logic [9:0]            fifo_wcnt,
    input  logic                  fifo_empty,
    output logic                  fifo_rst,
    hdmi_rd_sched_if.master       rd,
    output logic [10:0]           line_cnt,
    output logic [15:0]           frame_cnt,
    output logic                  underflow
);

    localparam int BURSTS = H_ACT / (BURST_BEATS * PIX_PER_BEAT);
    localparam int BIDX_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BIDX  = BIDX_W'(BURSTS - 1);
    localparam logic [27:0]       BURST_STEP = 28'(BURST_BEATS * BEAT_BYTES);
    localparam logic [27:0]       STRIDE     = 28'(LINE_STRIDE);
    localparam logic [10:0]       LAST_LINE  = 11'(V_ACT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_SPACE,
        REQ,
        WAIT_DATA,
        NEXT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              vs_prev_q, vs_prev_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [10:0]       line_q, line_d;
    logic [15:0]       frame_q, frame_d;
    logic              underflow_q, underflow_d;
    logic              pending_q, pending_d;
    logic [27:0]       addr_q, addr_d;
    logic [27:0]       line_base_q, line_base_d;

    logic frame_start;
    logic space_ok;

    assign frame_start = vs_in & ~vs_prev_q;
    assign space_ok    = (32'(fifo_wcnt) + 32'(BURST_BEATS)) <= 32'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vs_prev_q   <= 1'b0;
            bidx_q      <= '0;
            line_q      <= '0;
            frame_q     <= '0;
            underflow_q <= 1'b0;
            pending_q   <= 1'b0;
            addr_q      <= FB_BASE;
            line_base_q <= FB_BASE;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            bidx_q      <= bidx_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            underflow_q <= underflow_d;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vs_prev_d   = vs_in;
        bidx_d      = bidx_q;
        line_d      = line_q;
        frame_d     = frame_q;
        underflow_d = underflow_q | (de_in & fifo_empty);
        pending_d   = pending_q;
        addr_d      = addr_q;
        line_base_d = line_base_q;

        case (state_q)
            IDLE, DONE: begin
                if (frame_start) state_d = INIT;
            end
            INIT: begin
                line_d      = '0;
                bidx_d      = '0;
                addr_d      = FB_BASE;
                line_base_d = FB_BASE;
                underflow_d = 1'b0;
                pending_d   = 1'b0;
                frame_d     = frame_q + 16'd1;
                state_d     = sched_en ? WAIT_SPACE : IDLE;
            end
            WAIT_SPACE: begin
                if (frame_start)   state_d = INIT;
                else if (space_ok) state_d = REQ;
            end
            REQ: begin
                // a new frame never aborts an issued request; restart after it drains
                if (frame_start) pending_d = 1'b1;
                if (rd.rd_ack)   state_d   = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (frame_start) pending_d = 1'b1;
                if (rd.rd_done)  state_d   = (pending_q | frame_start) ? INIT : NEXT;
            end
            NEXT: begin
                if (frame_start) begin
                    state_d = INIT;
                end else if (bidx_q != LAST_BIDX) begin
                    bidx_d  = bidx_q + 1'b1;
                    addr_d  = addr_q + BURST_STEP;
                    state_d = WAIT_SPACE;
                end else begin
                    bidx_d      = '0;
                    line_d      = line_q + 11'd1;
                    line_base_d = line_base_q + STRIDE;
                    addr_d      = line_base_q + STRIDE;
                    state_d     = (line_q == LAST_LINE) ? DONE : WAIT_SPACE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_rst   = (state_q == INIT);
    assign rd.rd_req  = (state_q == REQ);
    assign rd.rd_addr = addr_q;
    assign rd.rd_len  = 8'(BURST_BEATS);
    assign line_cnt   = line_q;
    assign frame_cnt  = frame_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_hdmi_rd_sched.sv
// tb/tb_hdmi_rd_sched.sv - directed self-checking bench for hdmi_rd_sched (256x4 frame)
module tb_hdmi_rd_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       sched_en;
    logic       vs_in;
    logic       de_in;
    logic [9:0] fifo_wcnt;
    logic       fifo_empty;
    logic       fifo_rst;
    logic [10:0] line_cnt;
    logic [15:0] frame_cnt;
    logic       underflow;

    int total = 0;
    int bad   = 0;
    int fifo_rst_cnt = 0;
    int acc_cnt = 0;
    logic [27:0] addr_tab [0:7];

    hdmi_rd_sched_if bus ();

    hdmi_rd_sched #(
        .FB_BASE     (28'h0),
        .LINE_STRIDE (8192),
        .H_ACT       (256),
        .V_ACT       (4),
        .PIX_PER_BEAT(8),
        .BEAT_BYTES  (32),
        .BURST_BEATS (16),
        .FIFO_DEPTH  (512)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sched_en  (sched_en),
        .vs_in     (vs_in),
        .de_in     (de_in),
        .fifo_wcnt (fifo_wcnt),
        .fifo_empty(fifo_empty),
        .fifo_rst  (fifo_rst),
        .rd        (bus),
        .line_cnt  (line_cnt),
        .frame_cnt (frame_cnt),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rst) fifo_rst_cnt <= fifo_rst_cnt + 1;
        if (bus.rd_req && bus.rd_ack) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (bus.rd_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(bus.rd_req), 32'd1);
    endtask

    task automatic do_burst(input string tag, input logic [27:0] exp_addr);
        wait_req(tag, 20);
        chk({tag, "_addr"}, 32'(bus.rd_addr), 32'(exp_addr));
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.rd_req), 32'd0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
    endtask

    task automatic vs_pulse();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
    endtask

    initial begin
        logic seen;
        logic stable;
        int   acc0;
        int   frst0;

        addr_tab[0] = 28'h0000; addr_tab[1] = 28'h0200;
        addr_tab[2] = 28'h2000; addr_tab[3] = 28'h2200;
        addr_tab[4] = 28'h4000; addr_tab[5] = 28'h4200;
        addr_tab[6] = 28'h6000; addr_tab[7] = 28'h6200;

        rst = 1'b1; sched_en = 1'b0; vs_in = 1'b0; de_in = 1'b0;
        fifo_wcnt = '0; fifo_empty = 1'b0;
        bus.rd_ack = 1'b0; bus.rd_done = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_req", 32'(bus.rd_req), 32'd0);
        chk("rst_addr", 32'(bus.rd_addr), 32'h0);
        chk("rst_len", 32'(bus.rd_len), 32'd16);
        chk("rst_fifo_rst", 32'(fifo_rst), 32'd0);
        chk("rst_line", 32'(line_cnt), 32'd0);
        chk("rst_frame", 32'(frame_cnt), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // full frame, immediate ack/done
        sched_en = 1'b1;
        vs_pulse();
        chk("f1_fifo_rst", 32'(fifo_rst), 32'd1);
        for (int i = 0; i < 8; i++) do_burst($sformatf("f1_b%0d", i), addr_tab[i]);
        tick();
        chk("f1_line_done", 32'(line_cnt), 32'd4);
        chk("f1_frame", 32'(frame_cnt), 32'd1);
        chk("f1_fifo_rst_pulses", 32'(fifo_rst_cnt), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus.rd_req) seen = 1'b1; end
        chk("f1_done_holds", 32'(seen), 32'd0);
        chk("f1_line_hold", 32'(line_cnt), 32'd4);

        // FIFO space threshold
        fifo_wcnt = 10'd497;
        vs_pulse();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (bus.rd_req) seen = 1'b1; end
        chk("f2_no_space", 32'(seen), 32'd0);
        chk("f2_frame", 32'(frame_cnt), 32'd2);
        fifo_wcnt = 10'd496;
        tick();
        chk("f2_space_req", 32'(bus.rd_req), 32'd1);

        // delayed ack keeps request stable
        acc0 = acc_cnt;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.rd_req !== 1'b1 || bus.rd_addr !== 28'h0) stable = 1'b0;
            tick();
        end
        chk("f2_hold_stable", 32'(stable), 32'd1);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin if (bus.rd_req) seen = 1'b1; tick(); end
        chk("f2_wait_data_no_req", 32'(seen), 32'd0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        chk("f2_single_accept", 32'(acc_cnt - acc0), 32'd1);
        fifo_wcnt = 10'd0;
        do_burst("f2_b1", 28'h0200);
        do_burst("f2_b2", 28'h2000);

        // frame start while the 0x2200 burst is in flight
        wait_req("f2_b3", 20);
        chk("f2_b3_addr", 32'(bus.rd_addr), 32'h2200);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        frst0 = fifo_rst_cnt;
        vs_pulse();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin if (bus.rd_req || fifo_rst) seen = 1'b1; tick(); end
        chk("f2_restart_waits", 32'(seen), 32'd0);
        chk("f2_no_early_flush", 32'(fifo_rst_cnt - frst0), 32'd0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        chk("f3_fifo_rst", 32'(fifo_rst), 32'd1);
        tick();
        chk("f3_frame", 32'(frame_cnt), 32'd3);
        chk("f3_line", 32'(line_cnt), 32'd0);
        for (int i = 0; i < 8; i++) do_burst($sformatf("f3_b%0d", i), addr_tab[i]);
        tick();
        chk("f3_line_done", 32'(line_cnt), 32'd4);

        // underflow is sticky until the next INIT
        de_in = 1'b1; fifo_empty = 1'b0;
        tick();
        chk("uf_no_set", 32'(underflow), 32'd0);
        fifo_empty = 1'b1;
        tick();
        de_in = 1'b0; fifo_empty = 1'b0;
        chk("uf_set", 32'(underflow), 32'd1);
        tick(); tick(); tick();
        chk("uf_held", 32'(underflow), 32'd1);

        // sched_en low: flush and count the frame, but fetch nothing
        sched_en = 1'b0;
        vs_pulse();
        chk("f4_fifo_rst", 32'(fifo_rst), 32'd1);
        tick();
        chk("f4_uf_cleared", 32'(underflow), 32'd0);
        chk("f4_frame", 32'(frame_cnt), 32'd4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin if (bus.rd_req) seen = 1'b1; tick(); end
        chk("f4_no_req", 32'(seen), 32'd0);

        // reset mid-burst
        sched_en = 1'b1;
        vs_pulse();
        wait_req("f5", 20);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_frame", 32'(frame_cnt), 32'd0);
        chk("mid_rst_addr", 32'(bus.rd_addr), 32'h0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin if (bus.rd_req || fifo_rst) seen = 1'b1; tick(); end
        chk("mid_rst_idle", 32'(seen), 32'd0);
        chk("mid_rst_line", 32'(line_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
